// File: rtl/activation_pipe.sv
`default_nettype none
// ============================================================================
// Module   : activation_pipe
// Purpose  : Multi-lane signed fixed-point activation unit. Each beat carries
//            LANES values; each beat applies one of four activations:
//            bypass (or leaky ReLU), ReLU, piecewise-linear sigmoid, or tanh
//            (tanh(z) = 2*sigmoid(2z) - 1). The unit is a two-stage
//            valid/ready pipeline and counts saturated lanes for profiling.
// Options  : ACT_LEAKY_EN - when defined, mode 00 is leaky ReLU
//            (negative z -> z >>> 3); when undefined, mode 00 is pure bypass.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            mode      - 00 bypass/leaky, 01 ReLU, 10 sigmoid, 11 tanh
//            in_valid  - input beat valid
//            in_ready  - unit accepts a beat this cycle
//            z         - LANES signed inputs, lane i at [i*DATA_W +: DATA_W]
//            out_valid - result beat valid
//            out_ready - downstream accepts the result
//            dout      - LANES signed results, same packing as z
//            sat_clr   - clears sat_cnt (wins over an increment)
//            sat_cnt   - saturating count of saturated lanes
// Revision : 1.0 - initial release
// ============================================================================
module activation_pipe #(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 10,
    parameter int LANES     = 4,
    parameter int SAT_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] dout,
    input  logic                    sat_clr,
    output logic [SAT_CNT_W-1:0]    sat_cnt
);

    localparam logic [1:0] c_mode_byp  = 2'b00;
    localparam logic [1:0] c_mode_relu = 2'b01;
    localparam logic [1:0] c_mode_sig  = 2'b10;
    localparam logic [1:0] c_mode_tanh = 2'b11;

    // Sigmoid segment index, ordered by increasing |x|
    localparam logic [1:0] c_seg_lo  = 2'd0;   // a < 1.0
    localparam logic [1:0] c_seg_mid = 2'd1;   // 1.0   <= a < 2.375
    localparam logic [1:0] c_seg_hi  = 2'd2;   // 2.375 <= a < 5.0
    localparam logic [1:0] c_seg_sat = 2'd3;   // a >= 5.0

    localparam logic [DATA_W-1:0] c_one  = DATA_W'(1)  << FRAC_W;
    localparam logic [DATA_W-1:0] c_five = DATA_W'(5)  << FRAC_W;
    localparam logic [DATA_W-1:0] c_bnd2 = DATA_W'(19) << (FRAC_W - 3);
    localparam logic [DATA_W-1:0] c_off2 = DATA_W'(27) << (FRAC_W - 5);
    localparam logic [DATA_W-1:0] c_off1 = DATA_W'(5)  << (FRAC_W - 3);
    localparam logic [DATA_W-1:0] c_half = DATA_W'(1)  << (FRAC_W - 1);
    localparam logic [DATA_W-1:0] c_max  = {1'b0, {(DATA_W-1){1'b1}}};

    // Stage 1 registers
    logic                         v1_q,    v1_d;
    logic [1:0]                   mode1_q, mode1_d;
    logic [LANES-1:0]             sign1_q, sign1_d;
    logic [LANES-1:0]             ovf1_q,  ovf1_d;
    logic [LANES-1:0][DATA_W-1:0] a1_q,    a1_d;
    logic [LANES-1:0][1:0]        seg1_q,  seg1_d;
    logic [LANES-1:0][DATA_W-1:0] z1_q,    z1_d;

    // Stage 2 registers and counter
    logic                         v2_q,    v2_d;
    logic [LANES*DATA_W-1:0]      dout_q,  dout_d;
    logic [LANES-1:0]             sat2_q,  sat2_d;
    logic [SAT_CNT_W-1:0]         cnt_q,   cnt_d;

    // Per-lane combinational results
    logic [LANES-1:0]             w_sign;
    logic [LANES-1:0]             w_ovf;
    logic [LANES-1:0]             w_sat;
    logic [LANES-1:0][DATA_W-1:0] w_zl;
    logic [LANES-1:0][DATA_W-1:0] w_a;
    logic [LANES-1:0][DATA_W-1:0] w_res;
    logic [LANES-1:0][1:0]        w_seg;

    logic                         w_adv1;
    logic                         w_adv2;
    logic [SAT_CNT_W:0]           w_sum;

    // ------------------------------------------------------------------
    // Stage 1: magnitude and segment classification
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_s1
            // One extra bit holds both 2z and |most-negative| without loss,
            // so overflow is a plain magnitude compare against c_max.
            logic [DATA_W:0] w_ext;
            logic [DATA_W:0] w_abs;

            assign w_zl[i]   = z[i*DATA_W +: DATA_W];
            assign w_sign[i] = w_zl[i][DATA_W-1];
            assign w_ext     = (mode == c_mode_tanh) ? {w_zl[i], 1'b0}
                                                     : {w_zl[i][DATA_W-1], w_zl[i]};
            assign w_abs     = w_ext[DATA_W] ? (~w_ext + (DATA_W+1)'(1)) : w_ext;
            assign w_ovf[i]  = (w_abs > {1'b0, c_max});
            assign w_a[i]    = w_ovf[i] ? c_max : w_abs[DATA_W-1:0];
            assign w_seg[i]  = (w_a[i] >= c_five) ? c_seg_sat :
                               (w_a[i] >= c_bnd2) ? c_seg_hi  :
                               (w_a[i] >= c_one)  ? c_seg_mid : c_seg_lo;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2: per-lane activation result and saturation flag
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_s2
            logic [DATA_W-1:0] w_f;
            logic [DATA_W-1:0] w_s;
            logic [DATA_W-1:0] w_tanh;
            logic [DATA_W-1:0] w_relu;
            logic [DATA_W-1:0] w_byp;

            // Sigmoid of |x|; negative inputs reflect around 0.5
            assign w_f = (seg1_q[i] == c_seg_sat) ? c_one :
                         (seg1_q[i] == c_seg_hi)  ? (a1_q[i] >> 5) + c_off2 :
                         (seg1_q[i] == c_seg_mid) ? (a1_q[i] >> 3) + c_off1 :
                                                    (a1_q[i] >> 2) + c_half;
            assign w_s    = sign1_q[i] ? (c_one - w_f) : w_f;
            // s lies in [0, ONE], so 2s - ONE lies in [-ONE, ONE]
            assign w_tanh = (w_s << 1) - c_one;
            assign w_relu = z1_q[i][DATA_W-1] ? '0 : z1_q[i];
`ifdef ACT_LEAKY_EN
            assign w_byp  = z1_q[i][DATA_W-1] ? {{3{1'b1}}, z1_q[i][DATA_W-1:3]}
                                              : z1_q[i];
`else
            assign w_byp  = z1_q[i];
`endif
            assign w_res[i] = (mode1_q == c_mode_sig)  ? w_s    :
                              (mode1_q == c_mode_tanh) ? w_tanh :
                              (mode1_q == c_mode_relu) ? w_relu :
                                                         w_byp;
            // Overflow of |z| or |2z| counts in every mode
            assign w_sat[i] = (mode1_q[1] && (seg1_q[i] == c_seg_sat)) || ovf1_q[i];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake: a stage advances when it is empty or the stage after it
    // advances, so a full pipe shifts as a whole on an output handshake.
    // ------------------------------------------------------------------
    always_comb begin
        w_adv2 = !v2_q || out_ready;
        w_adv1 = !v1_q || w_adv2;
    end

    assign in_ready  = w_adv1;
    assign out_valid = v2_q;
    assign dout      = dout_q;
    assign sat_cnt   = cnt_q;

    always_comb begin
        v1_d    = v1_q;
        mode1_d = mode1_q;
        sign1_d = sign1_q;
        ovf1_d  = ovf1_q;
        a1_d    = a1_q;
        seg1_d  = seg1_q;
        z1_d    = z1_q;
        v2_d    = v2_q;
        dout_d  = dout_q;
        sat2_d  = sat2_q;

        if (w_adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                mode1_d = mode;
                sign1_d = w_sign;
                ovf1_d  = w_ovf;
                a1_d    = w_a;
                seg1_d  = w_seg;
                z1_d    = w_zl;
            end
        end

        if (w_adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                dout_d = w_res;
                sat2_d = w_sat;
            end
        end
    end

    // Saturating profile counter
    always_comb begin
        w_sum = {1'b0, cnt_q};
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + (SAT_CNT_W+1)'(sat2_q[i]);
        end

        cnt_d = cnt_q;
        if (sat_clr) begin
            cnt_d = '0;
        end else if (v2_q && out_ready) begin
            cnt_d = w_sum[SAT_CNT_W] ? '1 : w_sum[SAT_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            mode1_q <= '0;
            sign1_q <= '0;
            ovf1_q  <= '0;
            a1_q    <= '0;
            seg1_q  <= '0;
            z1_q    <= '0;
            v2_q    <= 1'b0;
            dout_q  <= '0;
            sat2_q  <= '0;
            cnt_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            mode1_q <= mode1_d;
            sign1_q <= sign1_d;
            ovf1_q  <= ovf1_d;
            a1_q    <= a1_d;
            seg1_q  <= seg1_d;
            z1_q    <= z1_d;
            v2_q    <= v2_d;
            dout_q  <= dout_d;
            sat2_q  <= sat2_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_activation_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_activation_pipe
// Purpose  : Self-checking bench for activation_pipe. A behavioural model
//            predicts each beat's results from the activation formulas; a
//            monitor compares every output handshake, the saturation counter
//            on every cycle, and output stability while stalled. Directed
//            beats pin literal values; a randomized phase covers the rest.
// Options  : ACT_LEAKY_EN - must match the RTL build (mode 00 behaviour).
// Revision : 1.0 - initial release
// ============================================================================
module tb_activation_pipe;

    localparam int DW   = 16;
    localparam int FW   = 10;
    localparam int L    = 4;
    localparam int CW   = 16;
    localparam int ONE  = 1 << FW;
    localparam int MAXP = (1 << (DW - 1)) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      mode;
    logic            in_valid;
    logic            in_ready;
    logic [L*DW-1:0] z;
    logic            out_valid;
    logic            out_ready;
    logic [L*DW-1:0] dout;
    logic            sat_clr;
    logic [CW-1:0]   sat_cnt;

    always #5 clk = ~clk;

    activation_pipe #(
        .DATA_W   (DW),
        .FRAC_W   (FW),
        .LANES    (L),
        .SAT_CNT_W(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .z        (z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .sat_clr  (sat_clr),
        .sat_cnt  (sat_cnt)
    );

    typedef struct {
        logic [L*DW-1:0] d;
        int              nsat;
    } exp_t;

    int              total = 0;
    int              bad   = 0;
    exp_t            q[$];
    int              m_cnt = 0;
    int              n_out = 0;
    logic            stall_prev = 1'b0;
    logic            rst_prev   = 1'b0;
    logic [L*DW-1:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Behavioural model: the activation formulas in plain integer arithmetic
    function automatic exp_t model(input logic [1:0] md, input logic [L*DW-1:0] zz);
        exp_t e;
        e.nsat = 0;
        e.d    = '0;
        for (int i = 0; i < L; i++) begin
            int zi, x, a, f, s, res;
            bit ovf;
            zi  = int'($signed(zz[i*DW +: DW]));
            x   = (md == 2'b11) ? 2 * zi : zi;
            a   = (x < 0) ? -x : x;
            ovf = (a > MAXP);
            if (ovf) a = MAXP;
            if (a >= 5 * ONE)           f = ONE;
            else if (a >= 19 * ONE / 8) f = a / 32 + 27 * ONE / 32;
            else if (a >= ONE)          f = a / 8 + 5 * ONE / 8;
            else                        f = a / 4 + ONE / 2;
            s = (x < 0) ? ONE - f : f;
            case (md)
                2'b10:   res = s;
                2'b11:   res = 2 * s - ONE;
                2'b01:   res = (zi < 0) ? 0 : zi;
`ifdef ACT_LEAKY_EN
                default: res = (zi < 0) ? (zi >>> 3) : zi;
`else
                default: res = zi;
`endif
            endcase
            e.d[i*DW +: DW] = res[DW-1:0];
            if ((md[1] && a >= 5 * ONE) || ovf) e.nsat++;
        end
        return e;
    endfunction

    // Monitor: sample mid-cycle, i.e. what the next rising edge will act on
    always @(negedge clk) begin
        exp_t e;
        if (rst_prev) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_dout", dout, 0);
            check("rst_in_ready", in_ready, 1);
        end
        check("sat_cnt", sat_cnt, m_cnt);
        if (stall_prev && !rst_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_dout", dout, held);
        end
        if (rst) begin
            q.delete();
            m_cnt      = 0;
            stall_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("dout", dout, e.d);
                    n_out++;
                    m_cnt = (m_cnt + e.nsat > 65535) ? 65535 : m_cnt + e.nsat;
                end
            end
            if (sat_clr) m_cnt = 0;
            if (in_valid && in_ready) q.push_back(model(mode, z));
            stall_prev = out_valid && !out_ready;
            held       = dout;
        end
        rst_prev = rst;
    end

    // Drive one beat until accepted; called and returns at posedge + 1
    task automatic send(input logic [1:0] md, input logic [L*DW-1:0] zz);
        int   guard = 0;
        logic acc;
        mode     = md;
        z        = zz;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) check("send_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    // Count negedges until out_valid is seen (bounded)
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_lane();
        logic [DW-1:0] bnd [8];
        bnd = '{16'h1400, 16'h13FF, 16'h0980, 16'h097F,
                16'h0400, 16'h03FF, 16'hEC00, 16'h0A00};
        case ($urandom % 6)
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hC000;
            3:       return bnd[$urandom % 8];
            4:       return DW'($urandom_range(0, 8191)) - DW'(4096);
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int n0;
        logic [L*DW-1:0] zr;
        logic [DW-1:0]   leaky_exp;

        rst = 1'b1; in_valid = 1'b0; mode = 2'b00; z = '0;
        out_ready = 1'b1; sat_clr = 1'b0;
        @(negedge clk);
        check("in_ready_in_rst", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Sigmoid: latency, literal lanes, one saturated lane
        send(2'b10, {16'h1800, 16'h0000, 16'hFC00, 16'h0400});
        wait_out(lat);
        check("sig_latency", lat, 2);
        check("sig_dout", dout, {16'h0400, 16'h0200, 16'h0100, 16'h0300});
        step();
        @(negedge clk);
        check("sig_sat_cnt", sat_cnt, 1);
        step();

        // Tanh: lanes 1.0, most-negative, 0, -1.0
        send(2'b11, {16'hFC00, 16'h0000, 16'h8000, 16'h0400});
        wait_out(lat);
        check("tanh_dout", dout, {16'hFD00, 16'h0000, 16'hFC00, 16'h0300});
        step();
        @(negedge clk);
        check("tanh_sat_cnt", sat_cnt, 2);
        step();

        // ReLU
        send(2'b01, {16'h0000, 16'h8000, 16'h1234, 16'hFEDD});
        wait_out(lat);
        check("relu_dout", dout, {16'h0000, 16'h0000, 16'h1234, 16'h0000});
        step();

        // Mode 00
`ifdef ACT_LEAKY_EN
        leaky_exp = 16'hFF00;
`else
        leaky_exp = 16'hF800;
`endif
        send(2'b00, {16'h0001, 16'h7FFF, 16'h0123, 16'hF800});
        wait_out(lat);
        check("mode0_dout", dout, {16'h0001, 16'h7FFF, 16'h0123, leaky_exp});
        step();

        // Backpressure: 8 beats with out_ready in a 1-0-0 pattern
        n0 = n_out;
        fork
            begin
                for (int b = 0; b < 8; b++) begin
                    for (int l = 0; l < L; l++) zr[l*DW +: DW] = rnd_lane();
                    send(2'(1 + (b % 3)), zr);
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    out_ready = (k % 3 == 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) step();
        check("bp_count", n_out - n0, 8);

        // sat_clr coincident with a saturating output handshake
        out_ready = 1'b0;
        send(2'b10, {4{16'h7FFF}});
        wait_out(lat);
        step();
        out_ready = 1'b1;
        sat_clr   = 1'b1;
        step();
        sat_clr   = 1'b0;
        @(negedge clk);
        check("clr_priority", sat_cnt, 0);
        step();

        // Drive the counter past all-ones: 16400 beats x 4 saturated lanes
        mode = 2'b10; z = {4{16'h7FFF}}; in_valid = 1'b1;
        repeat (16400) step();
        in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("sat_hold", sat_cnt, 16'hFFFF);
        step();
        send(2'b11, {4{16'h8000}});
        repeat (4) step();
        @(negedge clk);
        check("sat_hold2", sat_cnt, 16'hFFFF);
        step();

        // Randomized traffic with a mid-run reset
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom % 4) != 0;
            mode     = 2'($urandom);
            for (int l = 0; l < L; l++) z[l*DW +: DW] = rnd_lane();
            out_ready = ($urandom % 3) != 0;
            sat_clr   = ($urandom % 60) == 0;
            rst       = (c == 300);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0; rst = 1'b0;
        repeat (6) step();
        check("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
